// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
package timer_pkg;

  // Controller states: IDLE holds the count, RUN decrements on each tick.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Encoding of the mode input.
  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/tick_prescaler.sv
// Divides the enable input into a tick every PRESCALE enabled cycles.
// Instantiated by countdown_timer only when COUNTDOWN_PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt;

  assign tick = en && (pre_cnt == LAST);

  // Enabled-cycle counter; restarts on clear so a new period starts aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (clear || tick) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= pre_cnt + CW'(1);
    end
  end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot / periodic modes and a registered
// terminal-count pulse. Optional build macro COUNTDOWN_PRESCALE_EN inserts a
// tick prescaler so each decrement takes PRESCALE enabled cycles.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef COUNTDOWN_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
  // Prescaler realigns on every event that starts or ends a period.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en && (state == RUN)),
    .clear (stop || load || tc_next),
    .tick  (tick)
  );
`else
  assign tick = en;
`endif

  assign busy = (state == RUN);

  // Next-state logic with precedence stop > load > decrement.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    tc_next     = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else if (load) begin
      if (load_val != '0) begin
        count_next  = load_val;
        reload_next = load_val;
        state_next  = RUN;
      end else begin
        count_next = '0;
        state_next = IDLE;
      end
    end else if ((state == RUN) && tick) begin
      if (count <= WIDTH'(1)) begin
        // Terminal edge: mode is looked at only here.
        tc_next = 1'b1;
        if (mode == PERIODIC) begin
          count_next = reload;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end else begin
        count_next = count - WIDTH'(1);
      end
    end
  end

  // State, count, reload value and registered terminal-count pulse.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      tc     <= tc_next;
    end
  end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer (default build, no prescaler).
// The reference model tracks the period N and the number of enabled ticks
// since the last load, and derives count / tc / busy arithmetically.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         mode = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_active;
  int unsigned m_n;
  int unsigned m_t;
  int unsigned m_idle_count;
  bit          m_tc;

  countdown_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .stop     (stop),
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned model_count();
    if (m_active) return m_n - (m_t % m_n);
    return m_idle_count;
  endfunction

  task automatic model_reset();
    m_active     = 1'b0;
    m_n          = 1;
    m_t          = 0;
    m_idle_count = 0;
    m_tc         = 1'b0;
  endtask

  task automatic model_step();
    int unsigned cur;
    cur  = model_count();
    m_tc = 1'b0;
    if (stop) begin
      m_idle_count = cur;
      m_active     = 1'b0;
    end else if (load) begin
      if (load_val != 0) begin
        m_n      = load_val;
        m_t      = 0;
        m_active = 1'b1;
      end else begin
        m_active     = 1'b0;
        m_idle_count = 0;
      end
    end else if (m_active && en) begin
      m_t++;
      if (m_t % m_n == 0) begin
        m_tc = 1'b1;
        if (mode == 1'b0) begin
          m_active     = 1'b0;
          m_idle_count = 0;
        end
      end
    end
  endtask

  // One clock: update the model on the edge, compare 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("count", count, model_count());
    check("tc", tc, m_tc);
    check("busy", busy, m_active);
  endtask

  task automatic do_load(input int unsigned v, input logic m);
    load = 1'b1; load_val = W'(v); mode = m;
    cycle();
    load = 1'b0;
  endtask

  int unsigned tc_seen;
  int unsigned exp_seq[$];

  initial begin
    model_reset();
    #12 rst = 1'b1;
    #1;
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_tc", tc, 0);

    // One-shot: 3, 2, 1, 0 with a single tc as busy falls.
    en = 1'b1;
    do_load(3, 1'b0);
    check("os_load", count, 3);
    exp_seq = '{2, 1, 0};
    tc_seen = 0;
    foreach (exp_seq[i]) begin
      cycle();
      check("os_seq", count, exp_seq[i]);
      tc_seen += tc;
    end
    check("os_tc_busy", {tc, busy}, 2'b10);
    cycle();
    check("os_tc_once", tc_seen + tc, 1);

    // Periodic N=4 over three periods: tc every 4 cycles.
    do_load(4, 1'b1);
    tc_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("per_count", count, (i % 4 == 0) ? 4 : 4 - (i % 4));
      check("per_tc", tc, (i % 4 == 0) ? 1 : 0);
      tc_seen += tc;
    end
    check("per_tc_total", tc_seen, 3);
    stop = 1'b1; cycle(); stop = 1'b0;

    // Enable gating: 2, 1, 1, 1, then tc.
    en = 1'b1;
    do_load(2, 1'b0);
    exp_seq = '{1, 1, 1, 0};
    foreach (exp_seq[i]) begin
      en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      cycle();
      check("en_seq", count, exp_seq[i]);
      check("en_tc", tc, (i == 3) ? 1 : 0);
    end

    // Collision: reload at count 1 gives no tc; stop beats load.
    en = 1'b1;
    do_load(2, 1'b0);
    cycle();
    check("col_pre", count, 1);
    do_load(6, 1'b0);
    check("col_count", count, 6);
    check("col_tc", tc, 0);
    stop = 1'b1; load = 1'b1; load_val = 9;
    cycle();
    stop = 1'b0; load = 1'b0;
    check("stopload_count", count, 6);
    check("stopload_busy", busy, 0);

    // Zero load: idle at 0, never a tc.
    do_load(0, 1'b1);
    tc_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tc_seen += tc;
    end
    check("zero_count", count, 0);
    check("zero_tc", tc_seen, 0);

    // Reset mid-RUN at count 5, then no activity after release.
    do_load(8, 1'b0);
    repeat (3) cycle();
    check("rst_pre", count, 5);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_count", count, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_tc", tc, 0);
    #1 rst = 1'b1;
    en = 1'b1;
    repeat (3) cycle();
    check("rst_after", count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(99) < 75);
      load     = ($urandom_range(99) < 6);
      load_val = ($urandom_range(9) == 0) ? W'(0) : W'($urandom_range(9, 1));
      stop     = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 10) mode = $urandom_range(1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, width of count and load value.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 en  input  1  count enable; 0 freezes the count.
REQ-005 load  input  1  single-cycle strobe; captures load_val.
REQ-006 load_val  input  WIDTH  period / start value N.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic.
REQ-008 stop  input  1  abort; return to IDLE.
REQ-009 count  output  WIDTH  current count value.
REQ-010 tc  output  1  terminal-count pulse, one cycle wide, registered.
REQ-011 busy  output  1  1 while in RUN.

Function
REQ-012 The FSM SHALL have states IDLE and RUN.
REQ-013 Precedence SHALL be, per edge: stop > load > decrement.
REQ-014 load with load_val != 0 SHALL set count = load_val, reload = load_val, and state = RUN on the same edge.
REQ-015 load with load_val = 0 SHALL set count = 0 and state = IDLE, with no tc.
REQ-016 In RUN with en = 1 and count > 1, count SHALL decrement by 1 per enabled tick.
REQ-017 In RUN with en = 1 and count = 1, tc SHALL be 1 in the following cycle.
REQ-018 On that same edge, one-shot SHALL set count = 0 and state = IDLE; periodic SHALL set count = reload and stay in RUN.
REQ-019 Latency: load at edge k with N, continuous en SHALL give the first tc high after edge k+N; periodic SHALL give a tc every N cycles thereafter.
REQ-020 en = 0 SHALL hold count and state, with tc = 0.
REQ-021 The count SHALL never wrap below 0; IDLE SHALL hold count regardless of en.
REQ-022 load in RUN SHALL restart with the new value, with no tc that cycle, even if count = 1.
REQ-023 stop SHALL force IDLE and hold count, with tc = 0; stop and load together SHALL be treated as stop.
REQ-024 mode SHALL be sampled at the terminal edge only.
REQ-025 busy SHALL equal (state == RUN).

Reset
REQ-026 While rst = 0, the block SHALL asynchronously force count = 0, reload = 0, tc = 0, busy = 0, and state = IDLE.
REQ-027 Reset asserted mid-RUN SHALL discard the pending period; after release the block SHALL remain in IDLE until a load.

Configuration
REQ-028 With COUNTDOWN_PRESCALE_EN defined, the block SHALL gain parameter PRESCALE (default 4).
REQ-029 In that build, a decrement SHALL occur only on ticks where en = 1 and the prescaler reaches PRESCALE-1; the period SHALL then be N*PRESCALE cycles.
REQ-030 In that build, the prescaler SHALL clear on reset, load, stop, and each terminal edge.
REQ-031 Without COUNTDOWN_PRESCALE_EN, the tick SHALL equal en, with no prescaler logic present.

Structure
REQ-032 A package timer_pkg SHALL hold the state enum (IDLE, RUN) and the mode encoding constants ONE_SHOT = 0 and PERIODIC = 1.
REQ-033 The prescaler SHALL be a sub-module tick_prescaler, instantiated only under COUNTDOWN_PRESCALE_EN.

Verification
REQ-034 Reset check: rst low mid-RUN with count = 5 -> count = 0, busy = 0, tc = 0 immediately; after release, no decrement with en = 1.
REQ-035 One-shot check: load_val = 3, mode = 0, en = 1 -> count sequence 3, 2, 1, 0; tc high exactly one cycle; busy falls with tc.
REQ-036 Periodic check: load_val = 4, mode = 1 -> count sequence 4, 3, 2, 1, 4, 3...; tc every 4 cycles over 3 periods.
REQ-037 en-gating check: load_val = 2 with en toggling 1, 0, 0, 1 -> count sequence 2, 1, 1, 1, then tc; no tc while en = 0.
REQ-038 Collision check: count = 1 with load = 1 and load_val = 6 -> count = 6, no tc; stop and load in the same cycle -> IDLE, count held.
REQ-039 Zero-load check: load_val = 0 -> count = 0, busy = 0, tc never asserted.
